// File: rtl/detect_event_logger.sv
// Timestamps each detector pulse into a small first-word-fall-through FIFO
// and keeps saturating event/drop counters plus a sticky overflow flag.
module detect_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         total_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q, ovf_d;
    logic             pop_s, push_s, drop_s, full_s;

    // Handshake decode and next-state computation.
    always_comb begin
        full_s   = (level_q == LW'(DEPTH));
        pop_s    = (level_q != LW'(0)) && out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push_s   = det_in && (!full_s || pop_s);
        drop_s   = det_in && full_s && !pop_s;

        ts_d     = ts_q + TS_W'(1);
        wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (det_in && (total_q != {CNT_W{1'b1}})) begin
            total_d = total_q + CNT_W'(1);
        end else begin
            total_d = total_q;
        end

        if (drop_s && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end else begin
            drop_d = drop_q;
        end

        ovf_d = ovf_q | drop_s;
    end

    // Control state, counters and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            total_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            total_q  <= total_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage; contents are left as-is by reset.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_q[wr_ptr_q] <= ts_q;
        end
    end

    assign out_valid   = (level_q != LW'(0));
    // Gated so an empty FIFO never exposes stale storage (zero after reset).
    assign out_ts      = out_valid ? mem_q[rd_ptr_q] : TS_W'(0);
    assign fifo_level  = level_q;
    assign total_count = total_q;
    assign drop_count  = drop_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_detect_event_logger.sv
// Directed scenarios plus random traffic, every cycle compared with a
// queue-based model of the event logger.
module tb_detect_event_logger;

    localparam int TS_W  = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int MAXC  = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              det_in = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [TS_W-1:0]   out_ts;
    logic [2:0]        fifo_level;
    logic [CNT_W-1:0]  total_count;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_ts;
    logic [15:0] m_q[$];
    int          m_total;
    int          m_drop;
    bit          m_ovf;

    detect_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .det_in(det_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_ts(out_ts), .fifo_level(fifo_level),
        .total_count(total_count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model by the same edge, compare.
    task automatic step(input logic d, input logic r, input logic rs);
        int sz;
        bit pop, accept;
        det_in = d; out_ready = r; rst = rs;
        @(posedge clk);
        if (rs) begin
            m_ts = 16'h0000; m_q.delete(); m_total = 0; m_drop = 0; m_ovf = 1'b0;
        end else begin
            sz     = m_q.size();
            pop    = (sz != 0) && r;
            accept = d && ((sz < DEPTH) || pop);
            if (d && m_total < MAXC) m_total++;
            if (d && !accept) begin
                if (m_drop < MAXC) m_drop++;
                m_ovf = 1'b1;
            end
            if (pop) void'(m_q.pop_front());
            if (accept) m_q.push_back(m_ts);
            m_ts = m_ts + 16'h0001;
        end
        #1;
        check_val("valid", 32'(out_valid), 32'(m_q.size() != 0));
        check_val("level", 32'(fifo_level), 32'(m_q.size()));
        check_val("total", 32'(total_count), 32'(m_total));
        check_val("drop", 32'(drop_count), 32'(m_drop));
        check_val("ovf", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) check_val("ts", 32'(out_ts), 32'(m_q[0]));
        if (rs) check_val("ts_rst", 32'(out_ts), 32'h0);
    endtask

    task automatic idle_until(input logic [15:0] target, input logic r);
        for (int i = 0; i < 70000 && m_ts != target; i++) step(1'b0, r, 1'b0);
        check_val("idle_reach", 32'(m_ts), 32'(target));
    endtask

    initial begin
        // 1: single event at ts=3
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_val("rst_ts", 32'(out_ts), 32'h0);
        idle_until(16'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_val("t1_ts", 32'(out_ts), 32'h3);
        check_val("t1_lvl", 32'(fifo_level), 32'd1);
        check_val("t1_tot", 32'(total_count), 32'd1);

        // 2: overflow then in-order drain
        step(1'b0, 1'b0, 1'b1);
        idle_until(16'd5, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        check_val("t2_lvl", 32'(fifo_level), 32'd4);
        check_val("t2_tot", 32'(total_count), 32'd5);
        check_val("t2_drop", 32'(drop_count), 32'd1);
        check_val("t2_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_val("t2_drain", 32'(out_ts), 32'(5 + i));
            step(1'b0, 1'b1, 1'b0);
        end
        check_val("t2_empty", 32'(out_valid), 32'd0);
        check_val("t2_ovf_stk", 32'(overflow), 32'd1);

        // 3: push and pop together while full
        step(1'b0, 1'b0, 1'b1);
        idle_until(16'd10, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        idle_until(16'd20, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_val("t3_lvl", 32'(fifo_level), 32'd4);
        check_val("t3_drop", 32'(drop_count), 32'd0);
        check_val("t3_head", 32'(out_ts), 32'd11);
        check_val("t3_d1", 32'(out_ts), 32'd11); step(1'b0, 1'b1, 1'b0);
        check_val("t3_d2", 32'(out_ts), 32'd12); step(1'b0, 1'b1, 1'b0);
        check_val("t3_d3", 32'(out_ts), 32'd13); step(1'b0, 1'b1, 1'b0);
        check_val("t3_d4", 32'(out_ts), 32'd20); step(1'b0, 1'b1, 1'b0);

        // 4: timestamp wrap
        step(1'b0, 1'b1, 1'b1);
        idle_until(16'hFFFF, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check_val("t4_ffff", 32'(out_ts), 32'h0000FFFF);
        step(1'b1, 1'b1, 1'b0);
        check_val("t4_0000", 32'(out_ts), 32'h0);
        step(1'b0, 1'b1, 1'b0);

        // 5: counter saturation
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0);
        check_val("t5_tot", 32'(total_count), 32'd255);
        check_val("t5_drop0", 32'(drop_count), 32'd0);
        check_val("t5_ovf0", 32'(overflow), 32'd0);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
        check_val("t5_drop", 32'(drop_count), 32'd255);
        check_val("t5_tot2", 32'(total_count), 32'd255);

        // 6: reset mid-operation
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check_val("t6_lvl3", 32'(fifo_level), 32'd3);
        step(1'b1, 1'b0, 1'b1);
        check_val("t6_valid", 32'(out_valid), 32'd0);
        check_val("t6_tot", 32'(total_count), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check_val("t6_ts0", 32'(out_ts), 32'h0);
        check_val("t6_tot1", 32'(total_count), 32'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 299) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
